// File: rtl/conv3x3_param_fetch.sv
// Fetches one 3x3 kernel plus bias from the weight/bias ROMs and hands the
// packed bundle to the MAC engine over a valid/ready handshake.
module conv3x3_param_fetch #(
  parameter int NUM_FILTERS = 32,
  parameter int KERNEL      = 9,
  parameter int DATA_W      = 8,
  parameter int WADDR_W     = 9,
  parameter int BADDR_W     = 5,
  parameter int ROM_LAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [BADDR_W-1:0]       filter_idx_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [WADDR_W-1:0]       weight_addr_o,
  output logic [BADDR_W-1:0]       bias_addr_o,
  input  logic [DATA_W-1:0]        weight_q_i,
  input  logic [DATA_W-1:0]        bias_q_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [KERNEL*DATA_W-1:0] out_weights_o,
  output logic [DATA_W-1:0]        out_bias_o
);

  localparam int KW = (KERNEL > 1) ? $clog2(KERNEL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_e;

  state_e                   state_q;
  logic [KW-1:0]            k_q;
  logic [WADDR_W-1:0]       waddr_q;
  logic [BADDR_W-1:0]       baddr_q;
  logic                     err_q;
  logic                     valid_q;
  logic [KERNEL*DATA_W-1:0] weights_q;
  logic [DATA_W-1:0]        bias_q;
  logic [ROM_LAT-1:0]       tag_vld_q;
  logic [KW-1:0]            tag_k_q [ROM_LAT];

  logic               idx_ok;
  logic [WADDR_W-1:0] base;
  logic               last_issue;
  logic               cap_vld;
  logic [KW-1:0]      cap_k;
  logic               last_cap;

  assign idx_ok     = 32'(filter_idx_i) < NUM_FILTERS;
  assign base       = WADDR_W'(filter_idx_i) * WADDR_W'(KERNEL);
  assign last_issue = (k_q == KW'(KERNEL - 1));
  assign cap_vld    = tag_vld_q[ROM_LAT-1];
  assign cap_k      = tag_k_q[ROM_LAT-1];
  assign last_cap   = cap_vld && (cap_k == KW'(KERNEL - 1));

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      waddr_q <= '0;
      baddr_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (idx_ok) begin
              waddr_q <= base;
              baddr_q <= filter_idx_i;
              k_q     <= '0;
              state_q <= S_FETCH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (last_issue) begin
            k_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            k_q     <= k_q + 1'b1;
            waddr_q <= waddr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (last_cap) begin
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline mirrors the ROM latency; it keeps draining after FETCH ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_k_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= (state_q == S_FETCH);
      tag_k_q[0]   <= k_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_k_q[i]   <= tag_k_q[i-1];
      end
    end
  end

  // NOTE: the bundle registers are reset even though they are data, so a
  // reset mid-fetch never leaves a stale partial kernel on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_q <= '0;
      bias_q    <= '0;
    end else if (cap_vld) begin
      weights_q[int'(cap_k)*DATA_W +: DATA_W] <= weight_q_i;
      if (cap_k == '0) bias_q <= bias_q_i;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;
  assign weight_addr_o = waddr_q;
  assign bias_addr_o   = baddr_q;
  assign out_valid_o   = valid_q;
  assign out_weights_o = weights_q;
  assign out_bias_o    = bias_q;

endmodule

// File: tb/tb_conv3x3_param_fetch.sv
// Directed bench for conv3x3_param_fetch: three instances (default, 20 filters,
// two-cycle ROM) each with a behavioural ROM weight[a]=a mod 256, bias[b]=0x80+b.
module tb_conv3x3_param_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: defaults, ROM_LAT=1
  logic       start_a, busy_a, err_a, ov_a, rdy_a;
  logic [4:0] idx_a, ba_a, breg_a;
  logic [8:0] wa_a, wreg_a;
  logic [7:0] wq_a, bq_a, ob_a;
  logic [71:0] ow_a;

  // Instance B: NUM_FILTERS=20
  logic       start_b, busy_b, err_b, ov_b, rdy_b;
  logic [4:0] idx_b, ba_b, breg_b;
  logic [8:0] wa_b, wreg_b;
  logic [7:0] wq_b, bq_b, ob_b;
  logic [71:0] ow_b;

  // Instance C: ROM_LAT=2
  logic       start_c, busy_c, err_c, ov_c, rdy_c;
  logic [4:0] idx_c, ba_c, breg_c;
  logic [8:0] wa_c, wreg_c;
  logic [7:0] wq_c, bq_c, ob_c;
  logic [71:0] ow_c;

  always @(posedge clk) begin
    wreg_a <= wa_a;
    breg_a <= ba_a;
    wreg_b <= wa_b;
    breg_b <= ba_b;
    wreg_c <= wa_c;
    breg_c <= ba_c;
    wq_c   <= wreg_c[7:0];
    bq_c   <= 8'h80 + {3'b000, breg_c};
  end
  assign wq_a = wreg_a[7:0];
  assign bq_a = 8'h80 + {3'b000, breg_a};
  assign wq_b = wreg_b[7:0];
  assign bq_b = 8'h80 + {3'b000, breg_b};

  conv3x3_param_fetch u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .filter_idx_i(idx_a),
    .busy_o(busy_a), .err_o(err_a), .weight_addr_o(wa_a), .bias_addr_o(ba_a),
    .weight_q_i(wq_a), .bias_q_i(bq_a), .out_valid_o(ov_a), .out_ready_i(rdy_a),
    .out_weights_o(ow_a), .out_bias_o(ob_a)
  );

  conv3x3_param_fetch #(.NUM_FILTERS(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .filter_idx_i(idx_b),
    .busy_o(busy_b), .err_o(err_b), .weight_addr_o(wa_b), .bias_addr_o(ba_b),
    .weight_q_i(wq_b), .bias_q_i(bq_b), .out_valid_o(ov_b), .out_ready_i(rdy_b),
    .out_weights_o(ow_b), .out_bias_o(ob_b)
  );

  conv3x3_param_fetch #(.ROM_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .filter_idx_i(idx_c),
    .busy_o(busy_c), .err_o(err_c), .weight_addr_o(wa_c), .bias_addr_o(ba_c),
    .weight_q_i(wq_c), .bias_q_i(bq_c), .out_valid_o(ov_c), .out_ready_i(rdy_c),
    .out_weights_o(ow_c), .out_bias_o(ob_c)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_w(input int base);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'((base + k) % 256);
    return r;
  endfunction

  // Starts a fetch on instance A in cycle 0 and returns in cycle 11 (bundle up).
  task automatic fetch_a(input int idx);
    idx_a   = 5'(idx);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("a_waddr", wa_a, idx * 9 + k);
      check("a_busy_fetch", busy_a, 1);
      if (k == 0) check("a_baddr", ba_a, idx);
      @(negedge clk);
    end
    check("a_no_early_valid", ov_a, 0);
    @(negedge clk);
    check("a_valid", ov_a, 1);
    check("a_weights", ow_a, exp_w(idx * 9));
    check("a_bias", ob_a, 8'h80 + idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_a = 0; idx_a = 0; rdy_a = 0;
    start_b = 0; idx_b = 0; rdy_b = 0;
    start_c = 0; idx_c = 0; rdy_c = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_waddr", wa_a, 0);
    check("rst_baddr", ba_a, 0);
    check("rst_valid", ov_a, 0);
    check("rst_weights", ow_a, 0);
    check("rst_bias", ob_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Filter 2 with ready held high: handshake in cycle 11, idle in cycle 12
    rdy_a = 1'b1;
    fetch_a(2);
    @(negedge clk);
    check("t1_valid_drop", ov_a, 0);
    check("t1_busy_drop", busy_a, 0);
    check("t1_weights_held", ow_a, exp_w(18));

    // Back-to-back: last filter, addresses 279..287 wrap the weight data
    fetch_a(31);
    @(negedge clk);
    check("t2_valid_drop", ov_a, 0);
    check("t2_bias_held", ob_a, 8'h9F);

    // Stall 20 cycles with start pulses that must be ignored
    rdy_a = 1'b0;
    fetch_a(5);
    for (int i = 0; i < 20; i++) begin
      start_a = (i % 3 == 0);
      idx_a   = 5'd7;
      @(negedge clk);
      check("t3_hold_valid", ov_a, 1);
      check("t3_hold_weights", ow_a, exp_w(45));
      check("t3_hold_bias", ob_a, 8'h85);
      check("t3_hold_waddr", wa_a, 53);
    end
    start_a = 1'b1;
    rdy_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t3_handshake_valid", ov_a, 0);
    check("t3_handshake_busy", busy_a, 0);
    @(negedge clk);
    check("t3_start_ignored_busy", busy_a, 0);
    check("t3_start_ignored_waddr", wa_a, 53);

    // Out-of-range index on a 20-filter instance, then the highest legal one
    idx_b   = 5'd25;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("t4_err_pulse", err_b, 1);
    check("t4_err_busy", busy_b, 0);
    check("t4_err_waddr", wa_b, 0);
    check("t4_err_baddr", ba_b, 0);
    @(negedge clk);
    check("t4_err_clear", err_b, 0);
    check("t4_err_still_idle", busy_b, 0);
    rdy_b   = 1'b1;
    idx_b   = 5'd19;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("t4_legal_busy", busy_b, 1);
    check("t4_legal_waddr", wa_b, 171);
    check("t4_legal_err", err_b, 0);
    repeat (11) @(negedge clk);
    check("t4_legal_done", busy_b, 0);
    check("t4_legal_bias", ob_b, 8'h93);
    check("t4_legal_weights", ow_b, exp_w(171));

    // Asynchronous reset in FETCH at k=4
    idx_a   = 5'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_k4_waddr", wa_a, 31);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_waddr", wa_a, 0);
    check("t5_rst_baddr", ba_a, 0);
    check("t5_rst_valid", ov_a, 0);
    check("t5_rst_weights", ow_a, 0);
    check("t5_rst_bias", ob_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_partial_valid", ov_a, 0);
    check("t5_post_rst_idle", busy_a, 0);
    fetch_a(0);
    @(negedge clk);
    check("t5_valid_drop", ov_a, 0);

    // Two-cycle ROM: bundle appears in cycle 12
    rdy_c   = 1'b1;
    idx_c   = 5'd1;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("t6_waddr", wa_c, 9 + k);
      @(negedge clk);
    end
    check("t6_no_valid_c10", ov_c, 0);
    @(negedge clk);
    check("t6_no_valid_c11", ov_c, 0);
    @(negedge clk);
    check("t6_valid_c12", ov_c, 1);
    check("t6_weights", ow_c, exp_w(9));
    check("t6_bias", ob_c, 8'h81);
    @(negedge clk);
    check("t6_valid_drop", ov_c, 0);
    check("t6_busy_drop", busy_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
